// File: rtl/dualreg_pkg.sv
// rtl/dualreg_pkg.sv - state type and encodings shared by the dual skid register
package dualreg_pkg;

  localparam logic [1:0] EMPTY_ENC = 2'b00;
  localparam logic [1:0] FULL_ENC  = 2'b01;
  localparam logic [1:0] SKID_ENC  = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = EMPTY_ENC,
    FULL  = FULL_ENC,
    SKID  = SKID_ENC
  } state_t;

endpackage

// File: rtl/dual_field_reg.sv
// rtl/dual_field_reg.sv - two-field data register with load enable
module dual_field_reg #(
  parameter int M = 32,
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         load,
  input  logic [M-1:0] d1,
  input  logic [N-1:0] d2,
  output logic [M-1:0] q1,
  output logic [N-1:0] q2
);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q1 <= '0;
      q2 <= '0;
    end else if (load) begin
      q1 <= d1;
      q2 <= d2;
    end
  end

endmodule

// File: rtl/dual_skid_reg.sv
// rtl/dual_skid_reg.sv - two-entry skid pipeline stage with flush and stall counter
module dual_skid_reg
  import dualreg_pkg::*;
#(
  parameter int M  = 32,
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          FLUSH,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [M-1:0]  D1,
  input  logic [N-1:0]  D2,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [M-1:0]  Q1,
  output logic [N-1:0]  Q2,
  output logic [CW-1:0] STALL_CNT
);

  localparam logic [CW-1:0] STALL_MAX = '1;

  state_t       state, state_nxt;
  logic         accept, take;
  logic         main_load, skid_load;
  logic [M-1:0] skid_q1, main_d1;
  logic [N-1:0] skid_q2, main_d2;

  // Handshake outputs decode state only, so no comb path from OUT_READY/IN_VALID.
  assign IN_READY  = (state != SKID);
  assign OUT_VALID = (state != EMPTY);
  assign accept    = IN_VALID && IN_READY;
  assign take      = OUT_VALID && OUT_READY;

  assign main_d1 = (state == SKID) ? skid_q1 : D1;
  assign main_d2 = (state == SKID) ? skid_q2 : D2;

  always_comb begin
    state_nxt = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (accept && take) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_nxt = SKID;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (take) begin
          main_load = 1'b1;
          state_nxt = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A flush kills whatever moved this cycle and leaves the data untouched.
    if (FLUSH) begin
      state_nxt = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      STALL_CNT <= '0;
    end else if (OUT_VALID && !OUT_READY && (STALL_CNT != STALL_MAX)) begin
      STALL_CNT <= STALL_CNT + CW'(1);
    end
  end

  dual_field_reg #(.M(M), .N(N)) u_main (
    .CLK  (CLK),
    .RSTN (RSTN),
    .load (main_load),
    .d1   (main_d1),
    .d2   (main_d2),
    .q1   (Q1),
    .q2   (Q2)
  );

  dual_field_reg #(.M(M), .N(N)) u_skid (
    .CLK  (CLK),
    .RSTN (RSTN),
    .load (skid_load),
    .d1   (D1),
    .d2   (D2),
    .q1   (skid_q1),
    .q2   (skid_q2)
  );

endmodule
